// File: rtl/pwm_duty_decoder.sv
// ============================================================================
// Module   : pwm_duty_decoder
// Purpose  : Measures period and high time of an incoming PWM line and flags
//            an edge-free (static) line with its level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_duty_decoder #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             Enable,
    input  logic             Pulse_In,
    output logic [CNT_W-1:0] Period,
    output logic [CNT_W-1:0] Duty,
    output logic             Duty_Valid,
    output logic             Static,
    output logic             Static_Level
);

    localparam logic [CNT_W-1:0] c_all_ones   = '1;
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_timeout_m1 = CNT_W'(TIMEOUT - 1);

    generate
        if (TIMEOUT < 2 || TIMEOUT > (2 ** CNT_W) - 1) begin : g_param_check
            $error("TIMEOUT must lie in 2..2**CNT_W-1");
        end
    endgenerate

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_hi_cnt;
    logic             r_armed;

    logic             w_rise;
    logic             w_timeout;
    logic [CNT_W-1:0] w_per_inc;
    logic [CNT_W-1:0] w_hi_inc;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_timeout = (r_per_cnt == c_timeout_m1);

    // Counters saturate so the timeout compare can fire only once per idle stretch.
    assign w_per_inc = (r_per_cnt == c_all_ones) ? r_per_cnt : r_per_cnt + c_one;
    assign w_hi_inc  = (r_hi_cnt  == c_all_ones) ? r_hi_cnt  : r_hi_cnt  + c_one;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_per_cnt    <= '0;
            r_hi_cnt     <= '0;
            r_armed      <= 1'b0;
            Period       <= '0;
            Duty         <= '0;
            Duty_Valid   <= 1'b0;
            Static       <= 1'b0;
            Static_Level <= 1'b0;
        end else begin
            r_s1       <= Pulse_In;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            Duty_Valid <= 1'b0;

            if (!Enable) begin
                r_per_cnt <= '0;
                r_hi_cnt  <= '0;
                r_armed   <= 1'b0;
            end else if (w_rise) begin
                // An edge coinciding with the timeout wins: measure, never go static.
                if (r_armed) begin
                    Period     <= r_per_cnt;
                    Duty       <= r_hi_cnt;
                    Duty_Valid <= 1'b1;
                end
                r_per_cnt <= c_one;
                r_hi_cnt  <= c_one;
                r_armed   <= 1'b1;
                Static    <= 1'b0;
            end else begin
                if (w_timeout) begin
                    Static       <= 1'b1;
                    Static_Level <= r_s2;
                    Period       <= '0;
                    Duty         <= r_s2 ? c_all_ones : '0;
                    r_armed      <= 1'b0;
                    Duty_Valid   <= 1'b1;
                end
                r_per_cnt <= w_per_inc;
                if (r_s2) begin
                    r_hi_cnt <= w_hi_inc;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_decoder.sv
// ============================================================================
// Module   : tb_pwm_duty_decoder
// Purpose  : Scoreboard bench for pwm_duty_decoder with directed and random PWM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_duty_decoder;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 200;

    logic             sysclk   = 1'b0;
    logic             reset    = 1'b1;
    logic             Enable   = 1'b0;
    logic             Pulse_In = 1'b0;
    logic [CNT_W-1:0] Period;
    logic [CNT_W-1:0] Duty;
    logic             Duty_Valid;
    logic             Static;
    logic             Static_Level;

    pwm_duty_decoder #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .Enable       (Enable),
        .Pulse_In     (Pulse_In),
        .Period       (Period),
        .Duty         (Duty),
        .Duty_Valid   (Duty_Valid),
        .Static       (Static),
        .Static_Level (Static_Level)
    );

    always #5 sysclk = ~sysclk;

    typedef struct packed {
        int unsigned      edge_no;
        logic [CNT_W-1:0] per;
        logic [CNT_W-1:0] duty;
        logic             st;
        logic             lvl;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned edge_n      = 0;
    bit          hist[0:65535];
    bit          exp_static  = 1'b0;
    bit          exp_level   = 1'b0;

    // Reference model: the line as seen two clocks late; a measurement spans
    // rise to rise, high time is the count of high samples in that window.
    initial begin : model
        bit          m1, m2, m3, armed;
        int unsigned ref_e;
        int          per, duty;
        exp_t        e;
        m1 = 0; m2 = 0; m3 = 0; armed = 0; ref_e = 1;
        forever begin
            @(posedge sysclk or posedge reset);
            if (reset) begin
                m1 = 0; m2 = 0; m3 = 0; armed = 0;
                ref_e      = edge_n + 1;
                exp_static = 1'b0;
                exp_level  = 1'b0;
                exp_q.delete();
            end else begin
                edge_n++;
                hist[edge_n] = m2;
                per = int'(edge_n - ref_e);
                if (!Enable) begin
                    armed = 0;
                    ref_e = edge_n + 1;
                end else if (m2 && !m3) begin
                    if (armed) begin
                        duty = 0;
                        for (int unsigned k = ref_e; k < edge_n; k++) duty += int'(hist[k]);
                        e = '{edge_n, CNT_W'(per), CNT_W'(duty), 1'b0, exp_level};
                        exp_q.push_back(e);
                    end
                    armed      = 1;
                    ref_e      = edge_n;
                    exp_static = 1'b0;
                end else if (per == TIMEOUT - 1) begin
                    exp_static = 1'b1;
                    exp_level  = m2;
                    armed      = 0;
                    e = '{edge_n, '0, m2 ? {CNT_W{1'b1}} : {CNT_W{1'b0}}, 1'b1, m2};
                    exp_q.push_back(e);
                end
                m3 = m2; m2 = m1; m1 = Pulse_In;
            end
        end
    end

    initial begin : monitor
        logic [CNT_W-1:0] lp, ld;
        logic             ll;
        exp_t             e;
        lp = '0; ld = '0; ll = 1'b0;
        forever begin
            @(negedge sysclk);
            if (reset) begin
                lp = '0; ld = '0; ll = 1'b0;
            end else begin
                while (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
                    e = exp_q.pop_front();
                    miscompares++;
                    $display("FAIL missing_strobe: no strobe observed at edge %0d, required P=%0d D=%0d S=%0b L=%0b",
                             e.edge_no, e.per, e.duty, e.st, e.lvl);
                end
                if (Duty_Valid) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_strobe: edge %0d got P=%0d D=%0d S=%0b L=%0b, required no strobe",
                                 edge_n, Period, Duty, Static, Static_Level);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.edge_no != edge_n || Period != e.per || Duty != e.duty ||
                            Static != e.st || Static_Level != e.lvl) begin
                            miscompares++;
                            $display("FAIL strobe: got edge %0d P=%0d D=%0d S=%0b L=%0b, required edge %0d P=%0d D=%0d S=%0b L=%0b",
                                     edge_n, Period, Duty, Static, Static_Level,
                                     e.edge_no, e.per, e.duty, e.st, e.lvl);
                        end
                    end
                    lp = Period; ld = Duty; ll = Static_Level;
                end else if (Period != lp || Duty != ld || Static_Level != ll) begin
                    miscompares++;
                    $display("FAIL hold: edge %0d got P=%0d D=%0d L=%0b, required P=%0d D=%0d L=%0b",
                             edge_n, Period, Duty, Static_Level, lp, ld, ll);
                    lp = Period; ld = Duty; ll = Static_Level;
                end
                if (Static != exp_static) begin
                    miscompares++;
                    $display("FAIL static_flag: edge %0d got %0b, required %0b", edge_n, Static, exp_static);
                end
            end
        end
    end

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
            Pulse_In = v;
        end
    endtask

    task automatic pwm(input int hi, input int lo, input int reps);
        repeat (reps) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if (Period != '0 || Duty != '0 || Duty_Valid || Static || Static_Level) begin
            miscompares++;
            $display("FAIL %s: got P=%0d D=%0d V=%0b S=%0b L=%0b, required all zero",
                     name, Period, Duty, Duty_Valid, Static, Static_Level);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int p, h;
        #1;
        check_zero("reset_state");
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        reset  = 1'b0;
        Enable = 1'b1;

        pwm(63, 1, 10);                 // steady PWM
        drive(1'b0, 300);               // line drops low
        pwm(63, 1, 5);
        drive(1'b1, 300);               // line stuck high
        pwm(63, 1, 5);
        pwm(1, 1, 40);                  // minimum period

        pwm(63, 1, 3);                  // enable gating
        Enable = 1'b0;
        pwm(40, 10, 10);
        Enable = 1'b1;
        pwm(63, 1, 4);

        drive(1'b0, 250);               // rise on the timeout cycle vs. one cycle late
        drive(1'b1, 1); drive(1'b0, 198);
        drive(1'b1, 1); drive(1'b0, 198);
        drive(1'b1, 1); drive(1'b0, 199);
        drive(1'b1, 1); drive(1'b0, 198);
        drive(1'b1, 1); drive(1'b0, 300);

        pwm(63, 1, 3);                  // async reset mid high phase
        drive(1'b1, 30);
        @(negedge sysclk);
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        reset = 1'b0;
        pwm(63, 1, 4);

        for (int i = 0; i < 80; i++) begin
            p = int'($urandom_range(2, 230));
            h = int'($urandom_range(1, p - 1));
            Enable = ($urandom_range(0, 11) != 0);
            pwm(h, p - h, int'($urandom_range(1, 3)));
        end
        Enable = 1'b1;
        pwm(20, 30, 4);
        drive(1'b0, 300);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected strobes outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
